// File: rtl/servo_pwm_driver.sv
// Four-channel servo PWM driver with edge-detected command intake and frame-aligned width updates.
// Optional status outputs (last_servo, cmd_count) are enabled by defining SERVO_STATUS_EN.
module servo_pwm_driver #(
    parameter int CLK_PER_FRAME = 1000000,
    parameter int MIN_PULSE     = 50000,
    parameter int STEP          = 196
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] instruction,
    input  logic       instruction_ready,
    output logic       cmd_ack,
    output logic [3:0] pwm
`ifdef SERVO_STATUS_EN
    ,
    output logic [1:0] last_servo,
    output logic [7:0] cmd_count
`endif
);

    localparam int CW = $clog2(CLK_PER_FRAME);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_FRAME - 1);
    localparam logic [31:0] MIN_W = 32'(MIN_PULSE);
    localparam logic [31:0] STEP_W = 32'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic          rdy_q;
    logic          new_cmd;
    logic [9:0]    instr_reg;
    logic [CW-1:0] frame_cnt;
    logic          wrap;
    logic          latch_we;
    logic [7:0]    pending [4];
    logic [7:0]    active  [4];
    logic [3:0]    dirty;
    logic [31:0]   width   [4];

    assign new_cmd  = instruction_ready & ~rdy_q;
    assign wrap     = (frame_cnt == LAST);
    assign latch_we = (state == LATCH);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = new_cmd ? LATCH : IDLE;
            LATCH:   next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ack = (state == ACK);
    end

    // rdy_q starts high so a level held through reset is not a fresh command
    always_ff @(posedge clk) begin
        if (reset) begin
            rdy_q     <= 1'b1;
            instr_reg <= '0;
        end else begin
            rdy_q <= instruction_ready;
            if (state == IDLE && new_cmd) begin
                instr_reg <= instruction;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (wrap) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + CW'(1);
        end
    end

    // A LATCH write landing on the wrap cycle keeps dirty set for the next frame
    always_ff @(posedge clk) begin
        if (reset) begin
            dirty <= '0;
            for (int i = 0; i < 4; i++) begin
                pending[i] <= 8'd128;
                active[i]  <= 8'd128;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wrap && dirty[i]) begin
                    active[i] <= pending[i];
                    dirty[i]  <= 1'b0;
                end
                if (latch_we && instr_reg[9:8] == 2'(i)) begin
                    pending[i] <= instr_reg[7:0];
                    dirty[i]   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            width[i] = MIN_W + 32'(active[i]) * STEP_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pwm[i] <= (32'(frame_cnt) < width[i]);
            end
        end
    end

`ifdef SERVO_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            last_servo <= '0;
            cmd_count  <= '0;
        end else begin
            if (state == LATCH) begin
                last_servo <= instr_reg[9:8];
            end
            if (state == ACK) begin
                cmd_count <= cmd_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Self-checking bench for servo_pwm_driver: per-frame pulse widths via a scoreboard queue,
// plus command acknowledge timing, reset interactions and optional status outputs.
module tb_servo_pwm_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] instruction = '0;
    logic       instruction_ready = 1'b0;
    logic       cmd_ack;
    logic [3:0] pwm;
`ifdef SERVO_STATUS_EN
    logic [1:0] last_servo;
    logic [7:0] cmd_count;
`endif

    servo_pwm_driver #(
        .CLK_PER_FRAME(1000),
        .MIN_PULSE(50),
        .STEP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instruction(instruction),
        .instruction_ready(instruction_ready),
        .cmd_ack(cmd_ack),
        .pwm(pwm)
`ifdef SERVO_STATUS_EN
        ,
        .last_servo(last_servo),
        .cmd_count(cmd_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;
    logic rst_seen = 1'b1;
    int win = 0;
    int hi[4];
    logic seen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] wv(input int a, input int b,
                                       input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) step(1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        step(n);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic watch_ack(input int n, output logic any);
        any = 1'b0;
        repeat (n) begin
            step(1);
            any |= cmd_ack;
        end
    endtask

    // Frame windows: one window per 1000 samples after reset release
    always @(posedge clk) rst_seen <= reset;

    always @(negedge clk) begin
        if (rst_seen) begin
            win = 0;
            for (int i = 0; i < 4; i++) hi[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) hi[i] += int'(pwm[i]);
            win++;
            if (win == 1000) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        check($sformatf("width_ch%0d", i), 32'(hi[i]),
                              32'(mon_e[i*10+:10]));
                    end
                end
                win = 0;
                for (int i = 0; i < 4; i++) hi[i] = 0;
            end
        end
    end

    initial begin
        do_reset(3);
        check("reset_pwm", 32'(pwm), 32'd0);
        check("reset_ack", 32'(cmd_ack), 32'd0);
        exp_q.push_back(wv(178, 178, 178, 178));

        wait_to(1010);
        instruction = 10'h2FF;
        instruction_ready = 1'b1;
        exp_q.push_back(wv(178, 178, 178, 178));
        exp_q.push_back(wv(178, 178, 305, 178));
        step(1);
        check("ack_e0", 32'(cmd_ack), 32'd0);
        step(1);
        check("ack_e1", 32'(cmd_ack), 32'd1);
        step(1);
        check("ack_e2", 32'(cmd_ack), 32'd0);
        wait_to(1020);
        instruction_ready = 1'b0;

        // LATCH->ACK edge lands exactly on the wrap edge (cycle 3000)
        wait_to(2998);
        instruction = 10'h100;
        instruction_ready = 1'b1;
        exp_q.push_back(wv(178, 178, 305, 178));
        exp_q.push_back(wv(178, 50, 305, 178));
        step(2);
        check("ack_wrap", 32'(cmd_ack), 32'd1);
        wait_to(3010);
        instruction_ready = 1'b0;
        wait_to(5002);

        instruction_ready = 1'b1;
        do_reset(3);
        exp_q.push_back(wv(178, 178, 178, 178));
        watch_ack(8, seen);
        check("ack_held_rdy", 32'(seen), 32'd0);
        wait_to(1002);

        instruction_ready = 1'b0;
        step(2);
        instruction = 10'h300;
        instruction_ready = 1'b1;
        step(1);
        do_reset(2);
        exp_q.push_back(wv(178, 178, 178, 178));
        exp_q.push_back(wv(178, 178, 178, 178));
        watch_ack(8, seen);
        check("ack_rst_latch", 32'(seen), 32'd0);

        wait_to(1090);
        instruction_ready = 1'b0;
        wait_to(1100);
        instruction = 10'h0C0;
        instruction_ready = 1'b1;
        exp_q.push_back(wv(242, 178, 178, 178));
        exp_q.push_back(wv(242, 178, 178, 178));
        step(1);
        instruction_ready = 1'b0;
        step(1);
        check("ack_f", 32'(cmd_ack), 32'd1);
        instruction = 10'h33F;
        instruction_ready = 1'b1;
        step(1);
        check("ack_ignored", 32'(cmd_ack), 32'd0);
        watch_ack(6, seen);
        check("ack_no_queue", 32'(seen), 32'd0);
        wait_to(4002);

`ifdef SERVO_STATUS_EN
        instruction_ready = 1'b0;
        do_reset(2);
        check("status_rst_cnt", 32'(cmd_count), 32'd0);
        for (int n = 0; n < 256; n++) begin
            logic [7:0] b;
            b = 8'(n);
            instruction_ready = 1'b0;
            step(1);
            instruction = {b[1:0] ^ 2'b01, b};
            instruction_ready = 1'b1;
            step(4);
            if (n == 0) check("status_cnt1", 32'(cmd_count), 32'd1);
        end
        check("status_cnt256", 32'(cmd_count), 32'd0);
        check("status_last", 32'(last_servo), 32'd2);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pwm_driver.md
SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
REQ-001 SHALL have parameter CLK_PER_FRAME, default 1000000, meaning the PWM frame length in clk cycles (20 ms at 50 MHz).
REQ-002 SHALL have parameter MIN_PULSE, default 50000, meaning the high time in clk cycles for position 0.
REQ-003 SHALL have parameter STEP, default 196, meaning the extra high-time cycles per position LSB.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port instruction, input, 10 bits: [9:8] servo select 0-3, [7:0] position 0-255.
REQ-007 SHALL have port instruction_ready, input, 1 bit: level from the upstream deserializer, held high until the upstream is reset.
REQ-008 SHALL have port cmd_ack, output, 1 bit: one-cycle pulse when a command has been latched.
REQ-009 SHALL have port pwm, output, 4 bits: one servo pulse train per channel.

Function
REQ-010 SHALL register instruction_ready into rdy_q and treat (instruction_ready & !rdy_q) as a new command.
REQ-011 SHALL implement FSM IDLE->LATCH->ACK->IDLE, with encoding IDLE=0, LATCH=1, ACK=2; any other state code SHALL go to IDLE.
REQ-012 SHALL, in IDLE on a new command, capture instruction into instr_reg and go to LATCH; otherwise it SHALL stay in IDLE.
REQ-013 SHALL, in LATCH, write instr_reg[7:0] to pending[instr_reg[9:8]], set dirty[instr_reg[9:8]] and go to ACK.
REQ-014 SHALL, in ACK, drive cmd_ack=1 for exactly one cycle and go to IDLE; cmd_ack SHALL be 0 in every other state.
REQ-015 SHALL assert cmd_ack in the cycle two clocks after the clock edge that sampled the instruction_ready rise.
REQ-016 SHALL ignore new-command edges while in LATCH or ACK, with no queueing.
REQ-017 SHALL run frame_cnt 0..CLK_PER_FRAME-1 and wrap to 0 independently of the FSM.
REQ-018 SHALL, on the wrap cycle, copy pending[i] to active[i] and clear dirty[i] for every dirty channel, so width changes occur only at frame boundaries.
REQ-019 SHALL, when a LATCH write and a wrap fall in the same cycle, give active the pre-edge pending value and apply the new value at the following wrap; dirty SHALL remain set.
REQ-020 SHALL compute width[i] = MIN_PULSE + active[i]*STEP, zero-extended to the frame_cnt width with no truncation.
REQ-021 SHALL drive pwm[i] from a register as (frame_cnt < width[i]), giving 1 cycle of latency.
REQ-022 SHALL size frame_cnt to $clog2(CLK_PER_FRAME).

Reset
REQ-023 SHALL, on reset, set FSM=IDLE, cmd_ack=0, pwm=0, frame_cnt=0, instr_reg=0, dirty=0, and every pending[i] and active[i] to 128 (center).
REQ-024 SHALL set rdy_q=1 on reset, so an instruction_ready held high through reset is not taken as a new command.
REQ-025 SHALL, on reset asserted mid-command in LATCH or ACK, discard the command with no pending write and no cmd_ack.

Configuration
REQ-026 SHALL, with macro SERVO_STATUS_EN defined, add output last_servo (2 bits, reset 0), updated in LATCH, and output cmd_count (8 bits, reset 0), incremented in ACK and wrapping 255->0.
REQ-027 SHALL, without SERVO_STATUS_EN, have neither port nor its logic, with all other behaviour identical.

Verification (CLK_PER_FRAME=1000, MIN_PULSE=50, STEP=1)
REQ-028 SHALL test reset released, no command -> every pwm channel high 178 cycles per 1000-cycle frame.
REQ-029 SHALL test instruction=10'h2FF with an instruction_ready rise -> cmd_ack high one cycle, 2 clocks later; pwm[2] high 305 cycles from the next frame; the other channels stay at 178.
REQ-030 SHALL test the LATCH write of 10'h100 coinciding with the wrap -> pwm[1] stays at 178 for one more frame, then goes to 50.
REQ-031 SHALL test instruction_ready held high across reset -> no cmd_ack, and all widths remain 178.
REQ-032 SHALL test reset asserted in LATCH for 10'h300 -> no cmd_ack, and pwm[3] remains 178.
REQ-033 SHALL test, with SERVO_STATUS_EN, 256 commands -> cmd_count=0, and last_servo equal to the last select.
